stack_cpu: RTL and testbench
============================

// Module: stack_cpu
// PURPOSE
//  16-bit stack processor core: fetches one 16-bit instruction per access over a
//  single shared memory bus, executes it on an internal LIFO operand stack. Only
//  bus master in the system; external memory model (mem_test) supplies memory_ready.
// PARAMETERS
//  STACK_DEPTH  16  operand stack entries (power of 2, >=4)
//  RESET_PC     0   fetch address after reset
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  memory_ready  in   1   memory has completed current read/write
//  in_data       in   16  read data / fetched instruction
//  error         out  1   sticky fault flag
//  memory_w      out  1   1 = write cycle, 0 = read cycle
//  addr          out  16  memory address
//  out_data      out  16  write data
// BEHAVIOUR
//  - Reset: PC=RESET_PC, SP=0 (empty), state=FETCH; outputs error=0, memory_w=0,
//    addr=RESET_PC, out_data=0.
//  - Bus handshake: addr/memory_w/out_data held stable until an edge samples
//    memory_ready=1; that edge completes the access (read data latched from in_data).
//    memory_ready tied high = one-cycle accesses.
//  - States: FETCH (addr=PC, read; on ready IR<=in_data, PC<=PC+1) -> EXEC (1 cycle)
//    -> FETCH, or -> MEM for LOAD/STORE (wait ready) -> FETCH; HALT; FAULT.
//  - Opcode = IR[15:12], imm = IR[11:0] zero-extended to 16 bits:
//    0 NOP | 1 PUSHI imm | 2 ADD | 3 SUB (NOS-TOS) | 4 AND | 5 OR | 6 XOR
//    7 DUP | 8 DROP | 9 SWAP | A LOAD (pop a, push mem[a]) | B STORE (pop a,
//    pop d, mem[a]<=d) | C JMP imm (PC<=imm) | D JZ imm (pop v, v==0 -> PC<=imm)
//    E HALT | F illegal.
//  - Binary ops pop 2, push 1; arithmetic mod 2^16, no flags. PC wraps FFFF->0000.
//  - Stack underflow (pop from insufficient entries), overflow (push when full)
//    or opcode F -> FAULT: error=1 and stays 1 until reset; no further bus
//    activity (memory_w=0, addr frozen); faulting instruction has no side effect.
//  - HALT: memory_w=0, addr frozen, error=0; exits only via reset.
//  - memory_w=1 only during STORE in MEM state; out_data = stored value then,
//    otherwise holds last written value.
//  - Reset mid-access abandons the access immediately (memory_w drops to 0).
// STRUCTURE
//  - Package stack_cpu_pkg: opcode enum (4 bits), state enum, STACK_DEPTH default.
//  - One sub-module stack_cpu_stack: LIFO register file, exposes TOS/NOS,
//    push/pop/replace controls, full/count for overflow/underflow checks.
// TESTING
//  - in_data held 16'hC000, memory_ready=1, 20 clocks -> addr always 0000
//    (JMP 0 loop), memory_w never 1, error stays 0.
//  - Program PUSHI 5; PUSHI 3; ADD; PUSHI 40; STORE -> write cycle addr=0040,
//    out_data=0008, memory_w=1 exactly one access.
//  - First word 16'h2000 (ADD on empty stack) -> error=1 after EXEC, bus idle,
//    remains 1 over 10 further clocks; reset clears it.
//  - memory_ready low for 3 cycles during fetch -> addr held at PC, IR latched
//    only on ready edge, PC advances once.
//  - STACK_DEPTH+1 PUSHI -> error on the last push; 16'hE000 -> halt, error=0.
//  - Assert reset mid-STORE -> memory_w=0 asynchronously, addr=0000 next fetch.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared types and constants for the stack_cpu core.
package stack_cpu_pkg;

    localparam int unsigned DATA_W              = 16;
    localparam int unsigned IMM_W               = 12;
    localparam int unsigned STACK_DEPTH_DEFAULT = 16;

    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_PUSHI   = 4'h1,
        OP_ADD     = 4'h2,
        OP_SUB     = 4'h3,
        OP_AND     = 4'h4,
        OP_OR      = 4'h5,
        OP_XOR     = 4'h6,
        OP_DUP     = 4'h7,
        OP_DROP    = 4'h8,
        OP_SWAP    = 4'h9,
        OP_LOAD    = 4'hA,
        OP_STORE   = 4'hB,
        OP_JMP     = 4'hC,
        OP_JZ      = 4'hD,
        OP_HALT    = 4'hE,
        OP_ILLEGAL = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT,
        ST_FAULT
    } state_t;

    // Instruction word as fetched from the bus.
    typedef struct packed {
        opcode_t          op;
        logic [IMM_W-1:0] imm;
    } instr_t;

endpackage

// File: rtl/stack_cpu_stack.sv
// LIFO operand stack for stack_cpu.
//   clk, reset      : clock, async active-high reset (clears count only)
//   pop_cnt         : entries removed this cycle (0..2)
//   push, push_data : write one entry on top of what remains after pop_cnt
//   swap            : exchange TOS and NOS (caller ensures count >= 2)
//   tos_c, nos_c    : top / next-on-stack (undefined when not present)
//   count, full_c   : occupancy for underflow / overflow checks
module stack_cpu_stack
    import stack_cpu_pkg::*;
#(
    parameter int unsigned  DEPTH = STACK_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pop_cnt,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              swap,
    output logic [DATA_W-1:0] tos_c,
    output logic [DATA_W-1:0] nos_c,
    output logic [CNT_W-1:0]  count,
    output logic              full_c
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [PTR_W-1:0]  tos_idx;
    logic [PTR_W-1:0]  nos_idx;
    logic [PTR_W-1:0]  wr_idx;

    assign tos_idx = PTR_W'(count - CNT_W'(1));
    assign nos_idx = PTR_W'(count - CNT_W'(2));
    // A push lands just above whatever survives the pops of the same cycle.
    assign wr_idx  = PTR_W'(count - CNT_W'(pop_cnt));

    assign tos_c  = regs[tos_idx];
    assign nos_c  = regs[nos_idx];
    assign full_c = (count == CNT_W'(DEPTH));

    // Occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count - CNT_W'(pop_cnt) + CNT_W'(push);
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (swap) begin
            regs[tos_idx] <= nos_c;
            regs[nos_idx] <= tos_c;
        end else if (push) begin
            regs[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/stack_cpu.sv
// 16-bit stack processor: FETCH -> EXEC -> (MEM) -> FETCH over one memory bus.
//   clk, reset    : clock, async active-high reset
//   memory_ready  : completes the current bus access on the sampling edge
//   in_data       : read data / fetched instruction
//   error         : sticky fault flag (underflow, overflow, illegal opcode)
//   memory_w      : 1 = write cycle
//   addr          : bus address
//   out_data      : write data, holds last written value
module stack_cpu
    import stack_cpu_pkg::*;
#(
    parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              error,
    output logic              memory_w,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned STK_CNT_W = $clog2(STACK_DEPTH) + 1;

    state_t            state, state_d;
    logic [DATA_W-1:0] pc, pc_d;
    instr_t            ir, ir_d;
    logic [DATA_W-1:0] addr_d;
    logic              memory_w_d;
    logic [DATA_W-1:0] out_data_d;
    logic              error_d;

    logic [1:0]           stk_pop_cnt;
    logic                 stk_push;
    logic [DATA_W-1:0]    stk_push_data;
    logic                 stk_swap;
    logic [DATA_W-1:0]    tos_c, nos_c;
    logic [STK_CNT_W-1:0] stk_count;
    logic                 stk_full_c;

    logic [DATA_W-1:0] imm16;
    logic [DATA_W-1:0] alu_c;
    logic [1:0]        need_c;
    logic              grow_c;
    logic              fault_c;

    stack_cpu_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .pop_cnt   (stk_pop_cnt),
        .push      (stk_push),
        .push_data (stk_push_data),
        .swap      (stk_swap),
        .tos_c     (tos_c),
        .nos_c     (nos_c),
        .count     (stk_count),
        .full_c    (stk_full_c)
    );

    assign imm16 = DATA_W'(ir.imm);

    // Binary ALU, operands NOS (left) and TOS (right).
    always_comb begin
        alu_c = '0;
        case (ir.op)
            OP_ADD:  alu_c = nos_c + tos_c;
            OP_SUB:  alu_c = nos_c - tos_c;
            OP_AND:  alu_c = nos_c & tos_c;
            OP_OR:   alu_c = nos_c | tos_c;
            OP_XOR:  alu_c = nos_c ^ tos_c;
            default: alu_c = '0;
        endcase
    end

    // Stack entries each opcode needs, and whether it grows the stack.
    always_comb begin
        need_c = 2'd0;
        grow_c = 1'b0;
        case (ir.op)
            OP_PUSHI: grow_c = 1'b1;
            OP_DUP: begin
                need_c = 2'd1;
                grow_c = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP, OP_STORE: need_c = 2'd2;
            OP_DROP, OP_LOAD, OP_JZ: need_c = 2'd1;
            default: ;
        endcase
    end

    assign fault_c = (ir.op == OP_ILLEGAL)
                   || (stk_count < STK_CNT_W'(need_c))
                   || (grow_c && stk_full_c);

    // State register and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            addr     <= RESET_PC;
            memory_w <= 1'b0;
            out_data <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            addr     <= addr_d;
            memory_w <= memory_w_d;
            out_data <= out_data_d;
            error    <= error_d;
        end
    end

    // Next-state, datapath and stack control.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        ir_d          = ir;
        addr_d        = addr;
        memory_w_d    = memory_w;
        out_data_d    = out_data;
        error_d       = error;
        stk_pop_cnt   = 2'd0;
        stk_push      = 1'b0;
        stk_push_data = tos_c;
        stk_swap      = 1'b0;

        case (state)
            ST_FETCH: begin
                if (memory_ready) begin
                    ir_d    = instr_t'(in_data);
                    pc_d    = pc + DATA_W'(1);
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (fault_c) begin
                    // Faulting instruction leaves stack, PC and bus untouched.
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    case (ir.op)
                        OP_PUSHI: begin
                            stk_push      = 1'b1;
                            stk_push_data = imm16;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            stk_pop_cnt   = 2'd2;
                            stk_push      = 1'b1;
                            stk_push_data = alu_c;
                        end
                        OP_DUP:  stk_push    = 1'b1;
                        OP_DROP: stk_pop_cnt = 2'd1;
                        OP_SWAP: stk_swap    = 1'b1;
                        OP_LOAD: begin
                            stk_pop_cnt = 2'd1;
                            addr_d      = tos_c;
                            state_d     = ST_MEM;
                        end
                        OP_STORE: begin
                            stk_pop_cnt = 2'd2;
                            addr_d      = tos_c;
                            out_data_d  = nos_c;
                            memory_w_d  = 1'b1;
                            state_d     = ST_MEM;
                        end
                        OP_JMP: pc_d = imm16;
                        OP_JZ: begin
                            stk_pop_cnt = 2'd1;
                            if (tos_c == '0) begin
                                pc_d = imm16;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: ;
                    endcase
                    if (state_d == ST_FETCH) begin
                        addr_d = pc_d;
                    end
                end
            end

            ST_MEM: begin
                if (memory_ready) begin
                    // LOAD already popped its address in EXEC, so this push cannot overflow.
                    if (ir.op == OP_LOAD) begin
                        stk_push      = 1'b1;
                        stk_push_data = in_data;
                    end
                    memory_w_d = 1'b0;
                    addr_d     = pc;
                    state_d    = ST_FETCH;
                end
            end

            ST_HALT:  ;
            ST_FAULT: ;
            default:  state_d = ST_FAULT;
        endcase
    end

endmodule

// File: tb/tb_stack_cpu.sv
// Directed bench for stack_cpu with a write-access scoreboard.
module tb_stack_cpu;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        memory_ready;
    logic [15:0] in_data;
    logic        error;
    logic        memory_w;
    logic [15:0] addr;
    logic [15:0] out_data;

    logic [15:0] rom  [256];
    logic [15:0] wmem [256];
    int          wtag [256];
    int          test_id;

    wr_t exp_q[$];
    int  checks;
    int  errors;

    stack_cpu dut (
        .clk          (clk),
        .reset        (reset),
        .memory_ready (memory_ready),
        .in_data      (in_data),
        .error        (error),
        .memory_w     (memory_w),
        .addr         (addr),
        .out_data     (out_data)
    );

    // Words written during the current test shadow the program image.
    assign in_data = (wtag[addr[7:0]] == test_id) ? wmem[addr[7:0]] : rom[addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completing write access must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && memory_w && memory_ready) begin
            wmem[addr[7:0]] = out_data;
            wtag[addr[7:0]] = test_id;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, none expected", addr, out_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", addr, e.a);
                check("write_data", out_data, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_addr(input string name, input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (addr !== target && n < budget) begin
            step();
            n++;
        end
        check(name, addr, target);
    endtask

    task automatic wait_error(input string name, input int budget);
        int n;
        n = 0;
        while (error !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, 16'(error), 16'h0001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        memory_ready = 1'b1;

        // JMP 0 loop with in_data fixed at C000.
        test_id = 1;
        fill(16'hC000);
        reset_dut();
        check("rst_addr", addr, 16'h0000);
        check("rst_memory_w", 16'(memory_w), 16'h0000);
        check("rst_error", 16'(error), 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            step();
            check("jmp_loop_addr", addr, 16'h0000);
            check("jmp_loop_memory_w", 16'(memory_w), 16'h0000);
            check("jmp_loop_error", 16'(error), 16'h0000);
        end

        // PUSHI 5; PUSHI 3; ADD; PUSHI 40; STORE; HALT.
        test_id = 2;
        reset = 1'b1;
        fill(16'h0000);
        rom[0] = 16'h1005; rom[1] = 16'h1003; rom[2] = 16'h2000;
        rom[3] = 16'h1040; rom[4] = 16'hB000; rom[5] = 16'hE000;
        exp_q.push_back('{a: 16'h0040, d: 16'h0008});
        reset_dut();
        wait_addr("store_prog_halt_addr", 16'h0005, 40);
        repeat (3) step();
        check("store_prog_halt_addr_frozen", addr, 16'h0005);
        check("store_prog_error", 16'(error), 16'h0000);
        check("store_prog_memory_w", 16'(memory_w), 16'h0000);
        check("store_prog_out_data_held", out_data, 16'h0008);
        check("store_prog_pending", 16'(exp_q.size()), 16'h0000);

        // STORE, LOAD, SWAP, SUB wrap, taken JZ, DUP, ADD wrap.
        test_id = 3;
        reset = 1'b1;
        fill(16'h0000);
        rom[0]  = 16'h1123; rom[1]  = 16'h1042; rom[2]  = 16'hB000;
        rom[3]  = 16'h1042; rom[4]  = 16'hA000; rom[5]  = 16'h100F;
        rom[6]  = 16'h9000; rom[7]  = 16'h3000; rom[8]  = 16'h1000;
        rom[9]  = 16'hD00C; rom[10] = 16'hE000; rom[11] = 16'hE000;
        rom[12] = 16'h7000; rom[13] = 16'h2000; rom[14] = 16'h1043;
        rom[15] = 16'hB000; rom[16] = 16'hE000;
        exp_q.push_back('{a: 16'h0042, d: 16'h0123});
        exp_q.push_back('{a: 16'h0043, d: 16'hFDD8});
        reset_dut();
        wait_addr("mixed_prog_halt_addr", 16'h0010, 80);
        repeat (3) step();
        check("mixed_prog_halt_addr_frozen", addr, 16'h0010);
        check("mixed_prog_error", 16'(error), 16'h0000);
        check("mixed_prog_pending", 16'(exp_q.size()), 16'h0000);

        // ADD on an empty stack faults.
        test_id = 4;
        reset = 1'b1;
        fill(16'h0000);
        rom[0] = 16'h2000;
        reset_dut();
        wait_error("underflow_error", 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check("underflow_error_sticky", 16'(error), 16'h0001);
            check("underflow_memory_w", 16'(memory_w), 16'h0000);
            check("underflow_addr_frozen", addr, 16'h0000);
        end
        reset = 1'b1;
        #1;
        check("underflow_reset_clears", 16'(error), 16'h0000);

        // Fetch stalled by memory_ready low for 3 cycles.
        test_id = 5;
        fill(16'h0000);
        rom[0] = 16'h1007; rom[1] = 16'h1080; rom[2] = 16'hB000; rom[3] = 16'hE000;
        memory_ready = 1'b0;
        exp_q.push_back('{a: 16'h0080, d: 16'h0007});
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr_held", addr, 16'h0000);
        end
        memory_ready = 1'b1;
        step();
        check("stall_exec_addr", addr, 16'h0000);
        step();
        check("stall_pc_advanced_once", addr, 16'h0001);
        wait_addr("stall_prog_halt_addr", 16'h0003, 40);
        repeat (3) step();
        check("stall_prog_pending", 16'(exp_q.size()), 16'h0000);

        // STACK_DEPTH+1 pushes: last one overflows.
        test_id = 6;
        reset = 1'b1;
        fill(16'h0000);
        for (int i = 0; i < 17; i++) rom[i] = 16'h1001 + 16'(i);
        reset_dut();
        repeat (32) step();
        check("full_no_error", 16'(error), 16'h0000);
        check("full_next_fetch_addr", addr, 16'h0010);
        wait_error("overflow_error", 10);
        step();
        check("overflow_addr_frozen", addr, 16'h0010);
        check("overflow_memory_w", 16'(memory_w), 16'h0000);

        // HALT as first instruction.
        test_id = 7;
        reset = 1'b1;
        fill(16'hE000);
        reset_dut();
        repeat (5) step();
        check("halt_error", 16'(error), 16'h0000);
        check("halt_addr", addr, 16'h0000);
        check("halt_memory_w", 16'(memory_w), 16'h0000);

        // Reset asserted while a STORE waits for memory_ready.
        test_id = 8;
        reset = 1'b1;
        fill(16'h0000);
        rom[0] = 16'h1009; rom[1] = 16'h1050; rom[2] = 16'hB000; rom[3] = 16'hE000;
        reset_dut();
        repeat (5) step();
        memory_ready = 1'b0;
        begin
            int n;
            n = 0;
            while (memory_w !== 1'b1 && n < 5) begin
                step();
                n++;
            end
        end
        check("midstore_memory_w", 16'(memory_w), 16'h0001);
        check("midstore_addr", addr, 16'h0050);
        check("midstore_out_data", out_data, 16'h0009);
        reset = 1'b1;
        #1;
        check("midstore_reset_memory_w", 16'(memory_w), 16'h0000);
        check("midstore_reset_addr", addr, 16'h0000);
        memory_ready = 1'b1;
        exp_q.push_back('{a: 16'h0050, d: 16'h0009});
        step();
        reset = 1'b0;
        check("midstore_refetch_addr", addr, 16'h0000);
        wait_addr("midstore_rerun_halt_addr", 16'h0003, 40);
        repeat (3) step();
        check("midstore_pending", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
